// File: rtl/irq_priority_controller.sv
// irq_priority_controller: seven-level 68000 interrupt controller with pending/mask/status/swtrig registers.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   irq_pulse[6:0]               one-cycle edge pulses, bit i-1 = level i
//   sel, wr, rd, addr, wdata     glue-logic register bus (strobes qualified by sel)
//   rdata                        registered read data, valid the cycle after rd
//   ipl_n                        registered active-low encoded level to the CPU
//   iack, iack_level             IACK strobe and acknowledged level
//   vector, vector_valid         registered vector number and its one-cycle qualifier
module irq_priority_controller #(
    parameter logic [7:0] VECTOR_BASE     = 8'h40,
    parameter logic [7:0] SPURIOUS_VECTOR = 8'h18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] irq_pulse,
    input  logic       sel,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [2:0] ipl_n,
    input  logic       iack,
    input  logic [2:0] iack_level,
    output logic [7:0] vector,
    output logic       vector_valid
);
    function automatic logic [2:0] encode(input logic [7:1] v);
        encode = 3'd0;
        for (int i = 1; i <= 7; i++)
            if (v[i]) encode = i[2:0];
    endfunction

    logic [7:1] pending, mask, active, set_bits, clr_bits, pending_next, mask_next;
    logic [7:0] iack_hot, rd_val;
    logic [2:0] level;
    logic       wr_en, rd_en, iack_hit;

    always_comb begin
        wr_en        = sel & wr;
        rd_en        = sel & rd;
        iack_hot     = 8'd1 << iack_level;
        active       = pending & mask;
        level        = encode(active);
        set_bits     = irq_pulse | ((wr_en && addr == 2'd3) ? wdata[7:1] : 7'd0);
        // level 0 lands on bit 0 of the one-hot, which has no pending bit
        clr_bits     = ((wr_en && addr == 2'd0) ? wdata[7:1] : 7'd0) | (iack ? iack_hot[7:1] : 7'd0);
        // set wins over clear so an edge arriving with a clear is never lost
        pending_next = set_bits | (pending & ~clr_bits);
        mask_next    = (wr_en && addr == 2'd1) ? wdata[7:1] : mask;
        iack_hit     = |(active & iack_hot[7:1]);
        rd_val       = addr == 2'd0 ? {pending, 1'b0} :
                       addr == 2'd1 ? {mask, 1'b0} :
                       addr == 2'd2 ? {|active, 4'd0, level} : 8'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending      <= '0;
            mask         <= '0;
            ipl_n        <= 3'b111;
            rdata        <= 8'h00;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            pending      <= pending_next;
            mask         <= mask_next;
            // uses the incoming mask so a mask write reaches ipl_n one cycle later,
            // while new pending bits take the extra register stage
            ipl_n        <= ~encode(pending & mask_next);
            vector_valid <= iack;
            if (rd_en)
                rdata <= rd_val;
            if (iack)
                vector <= iack_hit ? VECTOR_BASE + {5'd0, iack_level} : SPURIOUS_VECTOR;
        end
    end
endmodule

// File: tb/tb_irq_priority_controller.sv
// tb_irq_priority_controller: scoreboard bench for irq_priority_controller.
module tb_irq_priority_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] irq_pulse = '0;
    logic       sel = 1'b0, wr = 1'b0, rd = 1'b0, iack = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] iack_level = '0;
    logic [7:0] rdata, vector;
    logic [2:0] ipl_n;
    logic       vector_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rd_q[$];
    logic [7:0] vec_q[$];

    irq_priority_controller dut (
        .clock(clock), .reset(reset), .irq_pulse(irq_pulse), .sel(sel), .wr(wr), .rd(rd),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ipl_n(ipl_n), .iack(iack),
        .iack_level(iack_level), .vector(vector), .vector_valid(vector_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // monitor: notes strobes at the edge, compares DUT outputs at the following negedge
    initial begin
        logic rd_seen, iack_seen;
        logic [7:0] e;
        forever begin
            @(posedge clock);
            rd_seen   = sel && rd && !reset;
            iack_seen = iack && !reset;
            @(negedge clock);
            if (rd_seen) begin
                n_tests++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_unexpected: rdata=%h with no expected value", rdata);
                end else begin
                    e = rd_q.pop_front();
                    if (rdata !== e) begin
                        n_fail++;
                        $display("FAIL read: rdata=%h expected %h", rdata, e);
                    end
                end
            end
            if (vector_valid !== iack_seen) begin
                n_tests++;
                n_fail++;
                $display("FAIL vector_valid: got %b expected %b", vector_valid, iack_seen);
            end else if (iack_seen) begin
                n_tests++;
                if (vec_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL vector_unexpected: vector=%h", vector);
                end else begin
                    e = vec_q.pop_front();
                    if (vector !== e) begin
                        n_fail++;
                        $display("FAIL vector: got %h expected %h", vector, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        sel = 1; wr = 1; addr = a; wdata = d;
        tick();
        sel = 0; wr = 0;
    endtask

    task automatic do_read(input logic [1:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        sel = 1; rd = 1; addr = a;
        tick();
        sel = 0; rd = 0;
    endtask

    task automatic do_iack(input logic [2:0] l, input logic [7:0] exp);
        vec_q.push_back(exp);
        iack = 1; iack_level = l;
        tick();
        iack = 0;
    endtask

    task automatic pulse(input logic [6:0] p);
        irq_pulse = p;
        tick();
        irq_pulse = '0;
    endtask

    task automatic check_ipl(input string name, input logic [2:0] exp);
        n_tests++;
        if (ipl_n !== exp) begin
            n_fail++;
            $display("FAIL %s: ipl_n=%b expected %b", name, ipl_n, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 0;
        repeat (10) tick();
        check_ipl("reset_ipl", 3'b111);
        n_tests++;
        if (vector !== 8'h00 || vector_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vector: vector=%h valid=%b expected 00 0", vector, vector_valid);
        end
        for (int a = 0; a < 4; a++) do_read(2'(a), 8'h00);

        // single level-3 source through to IACK
        do_write(2'd1, 8'hFE);
        pulse(7'b0000100);
        check_ipl("l3_latency_n1", 3'b111);
        tick();
        check_ipl("l3_latency_n2", 3'b100);
        do_read(2'd0, 8'h08);
        do_iack(3'd3, 8'h43);
        tick();
        check_ipl("l3_after_iack", 3'b111);
        do_read(2'd0, 8'h00);

        // two sources, W1C, then mask-off
        pulse(7'b0010010);
        tick();
        check_ipl("l2_l5", 3'b010);
        do_write(2'd0, 8'h20);
        tick();
        check_ipl("after_w1c_l5", 3'b101);
        do_write(2'd1, 8'h00);
        check_ipl("mask_off_latency", 3'b111);
        do_read(2'd0, 8'h04);

        // set beats clear in the same cycle
        do_write(2'd0, 8'h04);
        do_write(2'd1, 8'hFE);
        pulse(7'b0001000);
        irq_pulse = 7'b0001000;
        do_write(2'd0, 8'h10);
        irq_pulse = '0;
        do_read(2'd0, 8'h10);
        do_write(2'd0, 8'h10);
        do_read(2'd0, 8'h00);

        // spurious IACKs and software trigger
        do_iack(3'd6, 8'h18);
        do_read(2'd0, 8'h00);
        do_write(2'd3, 8'h80);
        do_read(2'd0, 8'h80);
        do_read(2'd2, 8'h87);
        do_read(2'd3, 8'h00);
        do_read(2'd1, 8'hFE);
        do_iack(3'd0, 8'h18);
        do_read(2'd0, 8'h80);
        do_iack(3'd7, 8'h47);
        do_read(2'd0, 8'h00);
        do_write(2'd1, 8'hFC);
        do_write(2'd3, 8'h02);
        do_iack(3'd1, 8'h18);
        do_read(2'd0, 8'h00);
        do_write(2'd1, 8'hFE);

        // reset overrides a concurrent IACK
        do_write(2'd3, 8'h82);
        tick();
        check_ipl("l7_l1", 3'b000);
        reset = 1; iack = 1; iack_level = 3'd7;
        tick();
        reset = 0; iack = 0;
        check_ipl("reset_mid_iack", 3'b111);
        n_tests++;
        if (vector !== 8'h00 || vector_valid !== 1'b0 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_iack_outputs: vector=%h valid=%b rdata=%h expected 00 0 00",
                     vector, vector_valid, rdata);
        end
        do_read(2'd0, 8'h00);
        do_read(2'd1, 8'h00);

        repeat (3) tick();
        n_tests++;
        if (rd_q.size() != 0 || vec_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: %0d reads %0d vectors left, expected 0 0", rd_q.size(), vec_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
